pe_bf_unified: RTL

- Parametrised successor of the fixed-constant butterfly PE. Performs one modular butterfly per cycle.
- Supports both Cooley-Tukey (forward NTT) and Gentleman-Sande (inverse NTT, with built-in halving) butterflies.
- The twiddle is supplied per sample, not hard-wired.
- Sits between the coefficient-memory read path and the write-back path of the NTT core. Adds valid tracking and a global stall so the controller no longer hand-counts latency.

---
 rtl/pe_bf_unified_pkg.sv | 21 ++
 rtl/pe_bf_unified_if.sv | 14 +
 rtl/pe_bf_unified_modmul_pipe.sv | 50 +++++
 rtl/pe_bf_unified.sv | 73 +++++++
 4 files changed

// File: rtl/pe_bf_unified_pkg.sv
// pe_pkg: shared defaults, mode encodings and modular helper functions for the butterfly PE.
package pe_pkg;
  localparam int DEF_DATA_WIDTH = 12;
  localparam int DEF_Q = 3329;
  localparam int DEF_MULT_LAT = 4;
  typedef enum logic {MODE_CT = 1'b0, MODE_GS = 1'b1} mode_e;
  function automatic logic [31:0] mod_add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= {1'b0, q}) ? 32'(s - {1'b0, q}) : s[31:0];
  endfunction
  function automatic logic [31:0] mod_sub(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q);
    return (a < b) ? a + q - b : a - b;
  endfunction
  // Odd values borrow one Q so the shift divides exactly by two modulo Q.
  function automatic logic [31:0] mod_half(input logic [31:0] x, input logic [31:0] q);
    logic [32:0] t;
    t = {1'b0, x} + (x[0] ? {1'b0, q} : 33'd0);
    return t[32:1];
  endfunction
endpackage

// File: rtl/pe_bf_unified_if.sv
// pe_bf_unified_if: sample-in / result-out bundle of the butterfly PE.
interface pe_bf_unified_if #(parameter int DATA_WIDTH = pe_pkg::DEF_DATA_WIDTH);
  logic en;
  logic in_valid;
  logic mode;
  logic [DATA_WIDTH-1:0] u;
  logic [DATA_WIDTH-1:0] v;
  logic [DATA_WIDTH-1:0] w;
  logic out_valid;
  logic [DATA_WIDTH-1:0] bf_upper;
  logic [DATA_WIDTH-1:0] bf_lower;
  modport master(output en, in_valid, mode, u, v, w, input out_valid, bf_upper, bf_lower);
  modport slave(input en, in_valid, mode, u, v, w, output out_valid, bf_upper, bf_lower);
endinterface

// File: rtl/pe_bf_unified_modmul_pipe.sv
// modmul_pipe: a*b mod Q via Barrett reduction, followed by MULT_LAT stall-aware register stages with a sideband delay line.
module modmul_pipe #(
  parameter int DATA_WIDTH = 12,
  parameter int Q = 3329,
  parameter int MULT_LAT = 4,
  parameter int SIDE_W = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [SIDE_W-1:0]     side_i,
  output logic [DATA_WIDTH-1:0] p_o,
  output logic [SIDE_W-1:0]     side_o
);
  localparam int K = 2 * DATA_WIDTH;
  localparam logic [K:0] M = (K+1)'((64'd1 << K) / 64'(Q));
  localparam logic [K-1:0] Q_K = K'(Q);
  logic [K-1:0] x, qe, r0, r1, r2;
  logic [DATA_WIDTH-1:0] p_d;
  logic [DATA_WIDTH-1:0] p_q [MULT_LAT];
  logic [SIDE_W-1:0] s_q [MULT_LAT];
  // With M = floor(2^K/Q) the quotient estimate is short by at most two, hence two corrections.
  always_comb begin
    x = {{DATA_WIDTH{1'b0}}, a_i} * {{DATA_WIDTH{1'b0}}, b_i};
    qe = K'(({{(K+1){1'b0}}, x} * {{K{1'b0}}, M}) >> K);
    r0 = x - qe * Q_K;
    r1 = (r0 >= Q_K) ? r0 - Q_K : r0;
    r2 = (r1 >= Q_K) ? r1 - Q_K : r1;
    p_d = DATA_WIDTH'(r2);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MULT_LAT; i++) begin
        p_q[i] <= '0;
        s_q[i] <= '0;
      end
    end else if (en) begin
      p_q[0] <= p_d;
      s_q[0] <= side_i;
      for (int i = 1; i < MULT_LAT; i++) begin
        p_q[i] <= p_q[i-1];
        s_q[i] <= s_q[i-1];
      end
    end
  end
  assign p_o = p_q[MULT_LAT-1];
  assign side_o = s_q[MULT_LAT-1];
endmodule

// File: rtl/pe_bf_unified.sv
// pe_bf_unified: pipelined CT/GS modular butterfly with per-sample twiddle, mode, valid tracking and global stall.
module pe_bf_unified
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int Q = DEF_Q,
  parameter int MULT_LAT = DEF_MULT_LAT
) (
  input logic             clk,
  input logic             rst,
  pe_bf_unified_if.slave  bus
);
  localparam int W = DATA_WIDTH;
  localparam logic [31:0] QW = 32'(Q);
  logic [W-1:0] u_q, v_q, w_q;
  logic mode_q, vld_q;
  logic [W-1:0] sum_s0, a_s0, d_s0, op_s0, keep_s0;
  logic [W-1:0] p, ud;
  logic vd, md;
  logic out_valid_q;
  logic [W-1:0] upper_q, lower_q, upper_d, lower_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      u_q <= '0;
      v_q <= '0;
      w_q <= '0;
      mode_q <= MODE_CT;
      vld_q <= 1'b0;
    end else if (bus.en) begin
      u_q <= bus.u;
      v_q <= bus.v;
      w_q <= bus.w;
      mode_q <= bus.mode;
      vld_q <= bus.in_valid;
    end
  end
  // GS needs (u+v)/2 on the side path and (u-v) into the multiplier; CT carries u and multiplies v.
  always_comb begin
    sum_s0 = W'(mod_add(32'(u_q), 32'(v_q), QW));
    a_s0 = W'(mod_half(32'(sum_s0), QW));
    d_s0 = W'(mod_sub(32'(u_q), 32'(v_q), QW));
    op_s0 = (mode_q == MODE_GS) ? d_s0 : v_q;
    keep_s0 = (mode_q == MODE_GS) ? a_s0 : u_q;
  end
  modmul_pipe #(.DATA_WIDTH(W), .Q(Q), .MULT_LAT(MULT_LAT), .SIDE_W(W + 2)) u_mul (
    .clk(clk),
    .rst(rst),
    .en(bus.en),
    .a_i(op_s0),
    .b_i(w_q),
    .side_i({vld_q, mode_q, keep_s0}),
    .p_o(p),
    .side_o({vd, md, ud})
  );
  always_comb begin
    upper_d = (md == MODE_GS) ? ud : W'(mod_add(32'(ud), 32'(p), QW));
    lower_d = (md == MODE_GS) ? W'(mod_half(32'(p), QW)) : W'(mod_sub(32'(ud), 32'(p), QW));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      upper_q <= '0;
      lower_q <= '0;
    end else if (bus.en) begin
      out_valid_q <= vd;
      upper_q <= upper_d;
      lower_q <= lower_d;
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.bf_upper = upper_q;
  assign bus.bf_lower = lower_q;
endmodule
